// File: rtl/fetch_sequencer.sv
// Instruction-side controller for the 8-bit core: fetch handshake, instruction
// latch, R-type write-back decode, branch-offset PC update and retire counter.
module fetch_sequencer #(
   parameter int DW       = 8,
   parameter int IW       = 8,
   parameter int PW       = 8,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic          imem_req,
   output logic [PW-1:0] imem_addr,
   input  logic          imem_ready,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] instr,
   input  logic [DW-1:0] alu_out,
   output logic          rf_we,
   output logic [1:0]    rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [PW-1:0] pc,
   output logic          retire,
   output logic [15:0]   icount,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t state;

   // Fetch handshake: imem_req is the valid and stays high with imem_addr
   // stable until the cycle imem_ready is seen high; that cycle transfers
   // imem_rdata. imem_ready/imem_rdata are ignored whenever imem_req is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= PW'(RESET_PC);
         instr  <= '0;
         icount <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (run) state <= FETCH;
            end
            FETCH: begin
               if (imem_ready) begin
                  instr <= imem_rdata;
                  state <= EXEC;
               end
            end
            EXEC: begin
               // Branch offset is unsigned; wrap-around provides backward reach.
               if (instr[0]) pc <= pc + alu_out[PW-1:0];
               else          pc <= pc + 1'b1;
               icount <= icount + 16'd1;
               state  <= run ? FETCH : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign retire    = (state == EXEC);
   assign rf_we     = (state == EXEC) && !instr[0];
   assign rf_waddr  = instr[5:4];
   assign rf_wdata  = alu_out;
   assign state_dbg = state;

endmodule
